// File: rtl/fetch_pipe_if.sv
// rtl/fetch_pipe_if.sv - instruction-memory port between the fetch stage and imem
`timescale 1ns/1ps
interface fetch_pipe_if;
    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic        addr_err_F;

    // fetch stage drives the address and the misalignment flag
    modport master (
        output pc_F,
        output addr_err_F,
        input  instr_F
    );

    // instruction memory answers combinationally; exception logic reads the flag
    modport slave (
        input  pc_F,
        input  addr_err_F,
        output instr_F
    );
endinterface

// File: rtl/fetch_pipe.sv
// rtl/fetch_pipe.sv - PC register, next-PC select and IF/ID register with delay slot
`timescale 1ns/1ps
module fetch_pipe #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic [1:0]          npc_sel,
    input  logic                branch_taken,
    input  logic [15:0]         imm16_D,
    input  logic [25:0]         index26_D,
    input  logic [31:0]         jr_target_D,
    fetch_pipe_if.master        imem,
    output logic [31:0]         instr_D,
    output logic [31:0]         pc_D,
    output logic                valid_D
);

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    logic [31:0] pc_f_q,    pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q,    pc_d_d;
    logic        valid_d_q, valid_d_d;

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;
    logic [31:0] next_pc;

    // next-PC candidates; all wrap modulo 2^32 and a redirect is only trusted from a real D instruction
    always_comb begin
        seq_pc  = pc_f_q + 32'd4;
        br_pc   = pc_d_q + 32'd4 + {{14{imm16_D[15]}}, imm16_D, 2'b00};
        jmp_pc  = {pc_d_q[31:28], index26_D, 2'b00};
        next_pc = seq_pc;
        if (valid_d_q) begin
            case (npc_sel)
                NPC_BR:  next_pc = branch_taken ? br_pc : seq_pc;
                NPC_J:   next_pc = jmp_pc;
                NPC_JR:  next_pc = jr_target_D;
                default: next_pc = seq_pc;
            endcase
        end
    end

    // reset beats stall beats normal advance; a stall holds everything so the redirect is replayed
    always_comb begin
        pc_f_d    = pc_f_q;
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        valid_d_d = valid_d_q;
        if (reset) begin
            pc_f_d    = PC_RESET;
            instr_d_d = 32'd0;
            pc_d_d    = 32'd0;
            valid_d_d = 1'b0;
        end else if (!stall) begin
            pc_f_d    = next_pc;
            instr_d_d = imem.instr_F;
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
        end
    end

    // PC and IF/ID state registers
    always_ff @(posedge clk) begin
        pc_f_q    <= pc_f_d;
        instr_d_q <= instr_d_d;
        pc_d_q    <= pc_d_d;
        valid_d_q <= valid_d_d;
    end

    assign imem.pc_F       = pc_f_q;
    assign imem.addr_err_F = (pc_f_q[1:0] != 2'b00);
    assign instr_D         = instr_d_q;
    assign pc_D            = pc_d_q;
    assign valid_D         = valid_d_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// tb/tb_fetch_pipe.sv - randomized and directed self-checking bench for fetch_pipe
`timescale 1ns/1ps
module tb_fetch_pipe;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [15:0] imm16_D;
    logic [25:0] index26_D;
    logic [31:0] jr_target_D;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic        valid_D;

    fetch_pipe_if imem ();

    fetch_pipe #(.PC_RESET(PC_RESET)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .imm16_D      (imm16_D),
        .index26_D    (index26_D),
        .jr_target_D  (jr_target_D),
        .imem         (imem),
        .instr_D      (instr_D),
        .pc_D         (pc_D),
        .valid_D      (valid_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem.instr_F = imem_word(imem.pc_F);

    int n_checks = 0;
    int n_fail   = 0;

    // reference state of the fetch stage
    logic [31:0] m_pc, m_pcd, m_instr;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next_pc();
        logic [31:0] off;
        off = 32'($signed(imm16_D)) * 32'd4;
        if (!m_valid) return m_pc + 32'd4;
        case (npc_sel)
            2'd1:    return branch_taken ? (m_pcd + 32'd4 + off) : (m_pc + 32'd4);
            2'd2:    return (m_pcd & 32'hF000_0000) | (32'(index26_D) * 32'd4);
            2'd3:    return jr_target_D;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    task automatic compare_all();
        chk("pc_F",       imem.pc_F,               m_pc);
        chk("pc_D",       pc_D,                    m_pcd);
        chk("instr_D",    instr_D,                 m_instr);
        chk("valid_D",    32'(valid_D),            32'(m_valid));
        chk("addr_err_F", 32'(imem.addr_err_F),    32'(m_pc % 4 != 0));
    endtask

    // one clock: predict from current inputs, clock the DUT, compare
    task automatic step();
        logic [31:0] npc;
        npc = model_next_pc();
        @(posedge clk);
        #1;
        if (reset) begin
            m_pc = PC_RESET; m_pcd = 0; m_instr = 0; m_valid = 0;
        end else if (!stall) begin
            m_instr = imem_word(m_pc);
            m_pcd   = m_pc;
            m_valid = 1'b1;
            m_pc    = npc;
        end
        compare_all();
    endtask

    task automatic drive(input logic r, input logic s, input logic [1:0] sel);
        reset = r; stall = s; npc_sel = sel;
    endtask

    initial begin
        m_pc = 0; m_pcd = 0; m_instr = 0; m_valid = 0;
        drive(1'b1, 1'b0, 2'd0);
        branch_taken = 0; imm16_D = 0; index26_D = 0; jr_target_D = 0;

        // reset and sequential run
        step();
        chk("rst_pc_F", imem.pc_F, 32'h3000);
        chk("rst_valid", 32'(valid_D), 32'd0);
        chk("rst_instr", instr_D, 32'd0);
        drive(1'b0, 1'b0, 2'd0);
        step();
        chk("seq1_pc_F", imem.pc_F, 32'h3004);
        chk("seq1_pc_D", pc_D, 32'h3000);
        chk("seq1_valid", 32'(valid_D), 32'd1);
        step();
        step();
        chk("seq3_pc_F", imem.pc_F, 32'h300C);
        chk("seq3_pc_D", pc_D, 32'h3008);

        // backward taken branch, delay slot enters D first
        drive(1'b0, 1'b0, 2'd1); branch_taken = 1; imm16_D = 16'hFFFE;
        step();
        chk("br_pc_F", imem.pc_F, 32'h3004);
        chk("br_slot_pc_D", pc_D, 32'h300C);
        chk("br_slot_instr", instr_D, imem_word(32'h300C));
        branch_taken = 0;
        step();
        chk("brnt_pc_F", imem.pc_F, 32'h3008);

        // jr to 0x3010, then j from pc_D=0x3010
        drive(1'b0, 1'b0, 2'd3); jr_target_D = 32'h3010;
        step();
        drive(1'b0, 1'b0, 2'd0);
        step();
        chk("j_pre_pc_D", pc_D, 32'h3010);
        drive(1'b0, 1'b0, 2'd2); index26_D = 26'h0000C10;
        step();
        chk("j_pc_F", imem.pc_F, 32'h3040);
        drive(1'b0, 1'b0, 2'd3); jr_target_D = 32'h3002;
        step();
        chk("jr_pc_F", imem.pc_F, 32'h3002);
        chk("jr_addr_err", 32'(imem.addr_err_F), 32'd1);

        // stall while a jump is pending in D
        jr_target_D = 32'h3100;
        step();
        drive(1'b0, 1'b0, 2'd0);
        step();
        drive(1'b0, 1'b1, 2'd2); index26_D = 26'h0000C80;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc_F", imem.pc_F, 32'h3104);
            chk("stall_pc_D", pc_D, 32'h3100);
        end
        drive(1'b0, 1'b0, 2'd2);
        step();
        chk("unstall_j_pc_F", imem.pc_F, 32'h3200);
        chk("unstall_pc_D", pc_D, 32'h3104);

        // reset wins over stall and jump
        drive(1'b1, 1'b1, 2'd2);
        step();
        chk("rst_stall_pc_F", imem.pc_F, 32'h3000);
        chk("rst_stall_pc_D", pc_D, 32'd0);
        chk("rst_stall_instr", instr_D, 32'd0);
        chk("rst_stall_valid", 32'(valid_D), 32'd0);

        // jump ignored while valid_D=0
        drive(1'b0, 1'b0, 2'd2); index26_D = 26'h3FF_FFFF;
        step();
        chk("guard_pc_F", imem.pc_F, 32'h3004);

        // wrap-around
        drive(1'b0, 1'b0, 2'd3); jr_target_D = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre_pc_F", imem.pc_F, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 2'd0);
        step();
        chk("wrap_pc_F", imem.pc_F, 32'h0000_0000);

        // randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            npc_sel      = 2'($urandom_range(0, 3));
            branch_taken = 1'($urandom_range(0, 1));
            imm16_D      = 16'($urandom);
            index26_D    = 26'($urandom);
            jr_target_D  = $urandom;
            if ($urandom_range(0, 7) != 0) jr_target_D[1:0] = 2'b00;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pipe.md
# fetch_pipe

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core. It holds the program counter, selects the next PC, and latches the fetched instruction and its PC into the decode stage. It drives the decode-stage PC that the link-address adder consumes. The core uses a branch delay slot: control transfers are resolved in D and never flush the instruction already fetched.

## Interface
- PC_RESET, 32'h0000_3000, PC value loaded by reset (text segment base)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  from hazard unit; freezes PC and IF/ID register
- npc_sel  in  2  from D-stage controller: 00 sequential, 01 branch, 10 j/jal, 11 jr/jalr
- branch_taken  in  1  D-stage comparator result; used only when npc_sel=01
- imm16_D  in  16  branch offset field of instr_D
- index26_D  in  26  jump index field of instr_D
- jr_target_D  in  32  forwarded rs value for jr/jalr
- instr_F  in  32  instruction-memory read data at address pc_F (combinational)
- pc_F  out  32  current fetch address to instruction memory
- instr_D  out  32  IF/ID instruction
- pc_D  out  32  IF/ID PC of instr_D
- valid_D  out  1  IF/ID holds a real fetched instruction
- addr_err_F  out  1  pc_F[1:0] != 0 (combinational)

## Operation
- PC register pc_F; IF/ID registers instr_D, pc_D, valid_D.
- Next-PC candidates, all 32-bit modulo 2^32, no overflow detection:
  - seq = pc_F + 4
  - br = pc_D + 4 + (sign_extend(imm16_D) << 2)
  - jmp = {pc_D[31:28], index26_D, 2'b00}
  - jr = jr_target_D, used unmodified
- Redirect selection:
  - npc_sel is honoured only when valid_D=1.
  - 01 with branch_taken=1 selects br.
  - 01 with branch_taken=0 selects seq.
  - 10 selects jmp.
  - 11 selects jr.
  - 00 selects seq.
  - valid_D=0 forces seq regardless of npc_sel.
- Priority per clock edge is reset > stall > normal.
- Reset:
  - pc_F <= PC_RESET
  - instr_D <= 0 (nop)
  - pc_D <= 0
  - valid_D <= 0
- Stall, with reset low: pc_F, instr_D, pc_D and valid_D all hold. The redirect is not lost, because the D instruction and its npc_sel are re-presented on the next unstalled cycle.
- Normal operation:
  - instr_D <= instr_F
  - pc_D <= pc_F
  - valid_D <= 1
  - pc_F <= selected next PC
- Delay slot: the instruction at pc_D+4 is already in pc_F when a redirect is taken. It enters D unconditionally; there is no flush input.
- addr_err_F is reported only. The block does not trap or correct the address; the exception logic consumes the flag.

## Timing
- Outputs are registered except addr_err_F. pc_F is a register output and the instruction memory is combinational, so instr_F is valid in the same cycle.
- Fetch-to-decode latency: 1 cycle. An instruction fetched at edge n appears on instr_D/pc_D after edge n+1.
- Redirect latency: a taken control transfer in D during cycle n updates pc_F at the end of cycle n. The target instruction reaches D two edges after the branch entered D; the delay slot sits between them.
- First cycle after reset is released: pc_F=PC_RESET and valid_D=0, so sequential fetch is forced. On the next edge pc_D=PC_RESET, valid_D=1 and pc_F=PC_RESET+4.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge and all state returns to reset values.
- Wrap-around: pc_F=32'hFFFF_FFFC sequential gives 32'h0000_0000. A branch target wraps modulo 2^32.

## Test plan
- Reset, then release with stall=0 and npc_sel=00 for 4 cycles. Required:
  - pc_F steps 0x3000, 0x3004, 0x3008, 0x300C.
  - pc_D lags by one cycle.
  - valid_D becomes 1 after the first edge.
- Branch backward, with pc_D=0x3008, npc_sel=01, branch_taken=1, imm16_D=16'hFFFE:
  - Next pc_F = 0x3004.
  - Delay-slot instruction 0x300C appears in D first.
  - The same case with branch_taken=0 gives pc_F=pc_F+4.
- Jump and jump-register:
  - pc_D=0x3010, npc_sel=10, index26_D=26'h0000C10 gives pc_F=0x0000_3040.
  - npc_sel=11, jr_target_D=0x0000_3002 gives pc_F=0x3002 and addr_err_F=1.
- Stall during a pending jump, with stall held for 3 cycles:
  - pc_F, instr_D and pc_D stay frozen.
  - After release, the jump takes effect on the first unstalled edge.
- Reset asserted simultaneously with stall=1 and npc_sel=10: next state is pc_F=0x3000, instr_D=0, pc_D=0, valid_D=0.
- Wrap and post-reset guard:
  - Force pc_F=0xFFFF_FFFC via jr; sequential next is 0x0000_0000.
  - npc_sel=10 driven while valid_D=0 is ignored; pc_F increments by 4.
